// File: rtl/i_mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// req/ack handshake with word address, lane-replicated write data and byte enables.
interface i_mem_access_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  o_dmem_req;
  logic                  o_dmem_we;
  logic [DATA_WIDTH-1:0] o_dmem_addr;
  logic [DATA_WIDTH-1:0] o_dmem_wdata;
  logic [BE_WIDTH-1:0]   o_dmem_be;
  logic                  i_dmem_ack;
  logic [DATA_WIDTH-1:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    input  i_dmem_ack, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    output i_dmem_ack, i_dmem_rdata
  );
endinterface

// File: rtl/i_mem_access.sv
// RISC-V memory-access stage: req/ack data bus, load formatting, registered writeback result.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses complete locally with o_IM_misaligned.
//
//   state | meaning
//   IDLE  | accepting instructions from execute; pass-through completes in 1 cycle
//   BUSY  | bus request outstanding, upstream stalled until i_dmem_ack
module i_mem_access #(
  parameter  int DATA_WIDTH = 32,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ctrl_valid,
  input  logic                  i_ctrl_mem_read,
  input  logic                  i_ctrl_mem_write,
  input  logic [2:0]            i_ctrl_funct3,
  input  logic [DATA_WIDTH-1:0] i_IE_result,
  input  logic [DATA_WIDTH-1:0] i_IE_data_write,
  output logic                  o_stall,
  i_mem_access_if.master        dmem,
  output logic                  o_IM_valid,
  output logic [DATA_WIDTH-1:0] o_IM_result,
  output logic                  o_IM_misaligned
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  mis_q, mis_d;
  logic                  mem_op;
  logic                  trap;

  assign mem_op = i_ctrl_mem_read | i_ctrl_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  logic acc_byte, acc_half;
  // Stores only recognise 000/001 as sub-word; loads also accept the unsigned encodings.
  always_comb begin
    if (i_ctrl_mem_write) begin
      acc_byte = (i_ctrl_funct3 == 3'b000);
      acc_half = (i_ctrl_funct3 == 3'b001);
    end else begin
      acc_byte = (i_ctrl_funct3[1:0] == 2'b00);
      acc_half = (i_ctrl_funct3[1:0] == 2'b01);
    end
  end
  assign trap = mem_op &&
                ((acc_half && i_IE_result[0]) ||
                 (!acc_half && !acc_byte && (i_IE_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [2:0] f3,
                                                     input logic [1:0] lane,
                                                     input logic [DATA_WIDTH-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'd0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = rdata;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      f3_q     <= 3'b000;
      lane_q   <= 2'b00;
      valid_q  <= 1'b0;
      result_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    valid_d  = 1'b0;
    result_d = result_q;
    mis_d    = mis_q;
    o_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ctrl_valid) begin
          if (!mem_op || trap) begin
            valid_d  = 1'b1;
            result_d = i_IE_result;
            mis_d    = trap;
          end else begin
            o_stall = 1'b1;
            req_d   = 1'b1;
            we_d    = i_ctrl_mem_write;
            addr_d  = {i_IE_result[DATA_WIDTH-1:2], 2'b00};
            lane_d  = i_IE_result[1:0];
            f3_d    = i_ctrl_funct3;
            state_d = BUSY;
            case (i_ctrl_funct3)
              3'b000:  wdata_d = {4{i_IE_data_write[7:0]}};
              3'b001:  wdata_d = {2{i_IE_data_write[15:0]}};
              default: wdata_d = i_IE_data_write;
            endcase
            if (!i_ctrl_mem_write) begin
              be_d = 4'b1111;
            end else begin
              case (i_ctrl_funct3)
                3'b000:  be_d = 4'b0001 << i_IE_result[1:0];
                3'b001:  be_d = i_IE_result[1] ? 4'b1100 : 4'b0011;
                default: be_d = 4'b1111;
              endcase
            end
          end
        end
      end
      BUSY: begin
        o_stall = !dmem.i_dmem_ack;
        if (dmem.i_dmem_ack) begin
          req_d    = 1'b0;
          valid_d  = 1'b1;
          mis_d    = 1'b0;
          result_d = we_q ? {addr_q[DATA_WIDTH-1:2], lane_q}
                          : fmt_load(f3_q, lane_q, dmem.i_dmem_rdata);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.o_dmem_req   = req_q;
  assign dmem.o_dmem_we    = we_q;
  assign dmem.o_dmem_addr  = addr_q;
  assign dmem.o_dmem_wdata = wdata_q;
  assign dmem.o_dmem_be    = be_q;
  assign o_IM_valid        = valid_q;
  assign o_IM_result       = result_q;
  assign o_IM_misaligned   = mis_q;

endmodule

// File: doc/i_mem_access.md
Name: i_mem_access

Overview:
- Memory-access stage of the RISC-V pipeline; consumes the execute-stage outputs (ALU result as address or data, store data).
- Drives a req/ack data-memory bus with byte enables.
- Formats load data with sign or zero extension and hands a registered result to writeback.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32: datapath and address width; only 32 is supported.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width. Not to be overridden.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- i_ctrl_valid  in  1  execute stage presents a valid instruction
- i_ctrl_mem_read  in  1  instruction is a load
- i_ctrl_mem_write  in  1  instruction is a store
- i_ctrl_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_IE_result  in  DATA_WIDTH  ALU result (byte address for loads/stores, else writeback data)
- i_IE_data_write  in  DATA_WIDTH  store data (rs2 contents)
- o_stall  out  1  upstream must hold its outputs this cycle
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = write, 0 = read
- o_dmem_addr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
- o_dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- o_dmem_be  out  BE_WIDTH  byte enables (write only; 4'b1111 on reads)
- i_dmem_ack  in  1  memory completes request; rdata valid same cycle
- i_dmem_rdata  in  DATA_WIDTH  read data word
- o_IM_valid  out  1  one-cycle pulse: o_IM_result valid
- o_IM_result  out  DATA_WIDTH  load data or passed-through ALU result
- o_IM_misaligned  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset is synchronous, active-low (`i_reset_n`); clock is `i_clk`.
- Reset values: state IDLE; o_dmem_req 0, o_dmem_we 0, o_dmem_addr 0, o_dmem_wdata 0, o_dmem_be 0; o_IM_valid 0, o_IM_result 0, o_IM_misaligned 0. Reset mid-transaction abandons it: req is 0 after the reset edge and no o_IM_valid is produced.
- FSM states: IDLE, BUSY.
- IDLE, i_ctrl_valid and neither mem flag set:
  - Pass-through: o_IM_result <= i_IE_result, o_IM_valid <= 1.
  - Latency 1; o_stall 0.
- IDLE, i_ctrl_valid and mem flag set (accept):
  - Register addr, we, be, wdata and funct3/addr[1:0] for formatting.
  - o_dmem_req <= 1; go to BUSY.
  - o_stall = 1 combinationally in the accept cycle.
- BUSY:
  - o_dmem_req and all bus fields are held stable until i_dmem_ack.
  - o_stall = !i_dmem_ack.
  - On ack: o_dmem_req <= 0; o_IM_valid <= 1; o_IM_result <= formatted rdata for a read, or the registered address for a write; go to IDLE.
  - Inputs presented during BUSY are ignored, because upstream is holding.
- Minimum memory-op latency: accept at cycle 0, req high at cycle 1, ack at cycle 1, o_IM_valid at cycle 2.
- i_dmem_ack while IDLE is ignored.
- Priority: mem_write and mem_read both set: treated as a store.
- Store enables and data:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = halfword replicated ×2.
  - SW: be = 1111.
  - Other funct3 on a store: treated as SW.
- Load formatting:
  - Byte lane selected by addr[1:0]; halfword lane selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
  - funct3 011/110/111 on a load: treated as LW.
- o_IM_valid is a single-cycle pulse; it is never high two cycles in a row for one instruction.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Misaligned is defined as: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Defined: a misaligned access is not sent to the bus.
  - The instruction completes from IDLE in 1 cycle with o_IM_valid=1, o_IM_misaligned=1, o_IM_result = faulting byte address.
  - o_stall is 0.
  - o_IM_misaligned is 0 on all other completions.
- Not defined: o_IM_misaligned is tied 0.
  - Misaligned accesses proceed; unused low address bits are ignored for lane selection (H uses addr[1] only; W ignores addr[1:0]).

Test Plan:
- Pass-through: valid, no mem flags, i_IE_result=0x0000_1234 -> next cycle o_IM_valid=1, o_IM_result=0x1234; o_stall stays 0; no req.
- SB: addr=0x103, data=0xAABBCCDD -> o_dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD, we=1. Ack held off 3 cycles -> req and fields stable, o_stall high until the ack cycle, then o_IM_valid one pulse.
- LB/LBU: addr=0x202, rdata=0x12F0_5634, ack immediate -> LB gives 0xFFFF_FFF0, LBU gives 0x0000_00F0; valid 2 cycles after accept.
- LH: addr=0x2, rdata=0x8001_7FFF -> 0xFFFF_8001. SW: addr=0x40 -> be=1111, wdata unchanged.
- Reset asserted in BUSY before ack -> next cycle req=0, state IDLE, no o_IM_valid; a later ack is ignored.
- MEM_MISALIGN_TRAP_EN defined: LW addr=0x102 -> no req, o_IM_valid=1, o_IM_misaligned=1, o_IM_result=0x102. Undefined: same stimulus -> req to 0x100, normal LW result.
